// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter: host (GPMC) priority, scanout anti-starvation, one-deep host holding register.
// Optional grant/defer statistics are compiled in when FB_ARB_STATS_EN is defined.
module fb_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  gpmc_clk,
    input  logic                  rst,
    input  logic                  host_rd_en,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rdata_valid,
    output logic                  host_overflow,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  scan_ack,
    output logic [DATA_WIDTH-1:0] scan_rdata,
    output logic                  scan_rdata_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef FB_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_host_grants,
    output logic [15:0]           stat_scan_grants,
    output logic [15:0]           stat_defers
`endif
);

    typedef enum logic [1:0] {GNT_IDLE, GNT_SCAN, GNT_HOLD, GNT_HOST} grant_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    grant_e                grant;
    logic                  host_ev, scan_want, hold_load;
    logic                  hold_vld_q, hold_vld_d, hold_we_q, hold_we_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [7:0]            starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_we_q, ram_we_d, ram_re_q, ram_re_d, tag_scan_q, tag_scan_d;
    logic                  rsp_vld_q, rsp_scan_q, ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, scan_rdata_q;
    logic                  host_vld_q, scan_vld_q;

    assign host_ev   = host_wr_en | host_rd_en;
    // The scan request is still high during its ack cycle; mask it so it is not issued twice.
    assign scan_want = scan_req & ~scan_ack;

    always_comb begin
        grant       = GNT_IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        tag_scan_d  = 1'b0;
        hold_vld_d  = hold_vld_q;
        hold_we_d   = hold_we_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_load   = 1'b0;
        ovf_d       = ovf_q;
        starve_d    = starve_q;

        if (scan_want && starve_q == LIMIT) grant = GNT_SCAN;
        else if (hold_vld_q)                grant = GNT_HOLD;
        else if (host_ev)                   grant = GNT_HOST;
        else if (scan_want)                 grant = GNT_SCAN;

        case (grant)
            GNT_SCAN: begin
                ram_addr_d = scan_addr;
                ram_re_d   = 1'b1;
                tag_scan_d = 1'b1;
            end
            GNT_HOLD: begin
                ram_addr_d  = hold_addr_q;
                ram_wdata_d = hold_data_q;
                ram_we_d    = hold_we_q;
                ram_re_d    = ~hold_we_q;
                hold_vld_d  = 1'b0;
            end
            GNT_HOST: begin
                ram_addr_d  = host_addr;
                ram_wdata_d = host_wdata;
                ram_we_d    = host_wr_en;
                ram_re_d    = ~host_wr_en;
            end
            default: ;
        endcase

        // A freshly granted holding entry frees the slot for this cycle's event.
        if (host_ev && grant != GNT_HOST) begin
            if (!hold_vld_q || grant == GNT_HOLD) begin
                hold_load   = 1'b1;
                hold_vld_d  = 1'b1;
                hold_we_d   = host_wr_en;
                hold_addr_d = host_addr;
                hold_data_d = host_wdata;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (!scan_want || grant == GNT_SCAN) starve_d = '0;
        else if (starve_q != LIMIT)          starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge gpmc_clk) begin
        if (rst) begin
            hold_vld_q   <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            starve_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            tag_scan_q   <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_scan_q   <= 1'b0;
            ovf_q        <= 1'b0;
            host_rdata_q <= '0;
            host_vld_q   <= 1'b0;
            scan_rdata_q <= '0;
            scan_vld_q   <= 1'b0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            starve_q     <= starve_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
            tag_scan_q   <= tag_scan_d;
            rsp_vld_q    <= ram_re_q;
            rsp_scan_q   <= tag_scan_q;
            ovf_q        <= ovf_d;
            host_vld_q   <= rsp_vld_q & ~rsp_scan_q;
            scan_vld_q   <= rsp_vld_q & rsp_scan_q;
            if (rsp_vld_q && !rsp_scan_q) host_rdata_q <= ram_rdata;
            if (rsp_vld_q && rsp_scan_q)  scan_rdata_q <= ram_rdata;
        end
    end

    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;
    assign ram_we           = ram_we_q;
    assign ram_re           = ram_re_q;
    assign scan_ack         = ram_re_q & tag_scan_q;
    assign host_rdata       = host_rdata_q;
    assign host_rdata_valid = host_vld_q;
    assign scan_rdata       = scan_rdata_q;
    assign scan_rdata_valid = scan_vld_q;
    assign host_overflow    = ovf_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] st_host_q, st_scan_q, st_def_q;

    always_ff @(posedge gpmc_clk) begin
        if (rst || stat_clr) begin
            st_host_q <= '0;
            st_scan_q <= '0;
            st_def_q  <= '0;
        end else begin
            if ((grant == GNT_HOST || grant == GNT_HOLD) && st_host_q != '1) st_host_q <= st_host_q + 16'd1;
            if (grant == GNT_SCAN && st_scan_q != '1) st_scan_q <= st_scan_q + 16'd1;
            if (hold_load && st_def_q != '1)          st_def_q  <= st_def_q + 16'd1;
        end
    end

    assign stat_host_grants = st_host_q;
    assign stat_scan_grants = st_scan_q;
    assign stat_defers      = st_def_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_rd_en, host_wr_en;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic        host_rdata_valid, host_overflow;
    logic        scan_req, scan_ack, scan_rdata_valid;
    logic [15:0] scan_addr, scan_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, ram_re;

    fb_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(8)) dut (
        .gpmc_clk(clk), .rst(rst),
        .host_rd_en(host_rd_en), .host_wr_en(host_wr_en), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
        .host_overflow(host_overflow), .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_ack(scan_ack), .scan_rdata(scan_rdata), .scan_rdata_valid(scan_rdata_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] hq_d[$], sq_d[$];
    int          hq_c[$], sq_c[$];
    logic [15:0] exp_d;
    int          exp_c;
    logic [69:0] outs;

    assign outs = {host_rdata, host_rdata_valid, host_overflow, scan_ack, scan_rdata,
                   scan_rdata_valid, ram_addr, ram_wdata, ram_we, ram_re};

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs;
        host_rd_en = 1'b0;
        host_wr_en = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        scan_req  = 1'b0;
        scan_addr = '0;
        tick();
        tick();
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (host_rdata_valid) begin
                checks++;
                if (hq_d.size() == 0) begin
                    errors++;
                    $display("FAIL wr_rd_unexpected_valid: got data %h at cycle %0d, expected no valid", host_rdata, cyc);
                end else begin
                    exp_d = hq_d.pop_front();
                    exp_c = hq_c.pop_front();
                    if (host_rdata !== exp_d || cyc != exp_c) begin
                        errors++;
                        $display("FAIL wr_rd_data: got %h at cycle %0d, expected %h at cycle %0d", host_rdata, cyc, exp_d, exp_c);
                    end
                end
            end
            if (i == 1) begin
                checks++;
                if ({ram_we, ram_re, ram_addr, ram_wdata} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF}) begin
                    errors++;
                    $display("FAIL wr_ram_strobe: got we=%b re=%b addr=%h wdata=%h, expected we=1 re=0 addr=0010 wdata=beef",
                             ram_we, ram_re, ram_addr, ram_wdata);
                end
            end
            if (i == 3) begin
                checks++;
                if ({ram_we, ram_re, ram_addr} !== {1'b0, 1'b1, 16'h0010}) begin
                    errors++;
                    $display("FAIL rd_ram_strobe: got we=%b re=%b addr=%h, expected we=0 re=1 addr=0010", ram_we, ram_re, ram_addr);
                end
            end
            idle_inputs();
            case (i)
                0: begin host_wr_en = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF; end
                2: begin host_rd_en = 1'b1; host_addr = 16'h0010; hq_d.push_back(16'hBEEF); hq_c.push_back(cyc + 3); end
                3: begin host_wr_en = 1'b1; host_addr = 16'h0011; host_wdata = 16'hCAFE; end
                4: begin host_rd_en = 1'b1; host_addr = 16'h0011; hq_d.push_back(16'hCAFE); hq_c.push_back(cyc + 3); end
                default: ;
            endcase
        end
        checks++;
        if (hq_d.size() != 0) begin
            errors++;
            $display("FAIL wr_rd_missing: got %0d responses outstanding, expected 0", hq_d.size());
        end
    endtask

    task automatic test_wr_rd_both;
        hq_d.delete();
        hq_c.delete();
        for (int i = 0; i < 9; i++) begin
            tick();
            if (host_rdata_valid) begin
                checks++;
                if (hq_d.size() == 0) begin
                    errors++;
                    $display("FAIL both_unexpected_valid: got data %h at cycle %0d, expected no valid", host_rdata, cyc);
                end else begin
                    exp_d = hq_d.pop_front();
                    exp_c = hq_c.pop_front();
                    if (host_rdata !== exp_d || cyc != exp_c) begin
                        errors++;
                        $display("FAIL both_readback: got %h at cycle %0d, expected %h at cycle %0d", host_rdata, cyc, exp_d, exp_c);
                    end
                end
            end
            if (i == 1) begin
                checks++;
                if ({ram_we, ram_re, ram_addr, ram_wdata} !== {1'b1, 1'b0, 16'h0005, 16'h1234}) begin
                    errors++;
                    $display("FAIL both_write: got we=%b re=%b addr=%h wdata=%h, expected we=1 re=0 addr=0005 wdata=1234",
                             ram_we, ram_re, ram_addr, ram_wdata);
                end
            end
            if (i == 2) begin
                checks++;
                if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
                    errors++;
                    $display("FAIL both_single_access: got we=%b re=%b, expected 0 0", ram_we, ram_re);
                end
            end
            idle_inputs();
            case (i)
                0: begin host_wr_en = 1'b1; host_rd_en = 1'b1; host_addr = 16'h0005; host_wdata = 16'h1234; end
                4: begin host_rd_en = 1'b1; host_addr = 16'h0005; hq_d.push_back(16'h1234); hq_c.push_back(cyc + 3); end
                default: ;
            endcase
        end
        checks++;
        if (hq_d.size() != 0) begin
            errors++;
            $display("FAIL both_missing: got %0d responses outstanding, expected 0", hq_d.size());
        end
    endtask

    task automatic test_scan;
        int t0 = 0;
        bit acked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (scan_ack) begin
                checks++;
                if (acked || cyc != t0 + 1) begin
                    errors++;
                    $display("FAIL scan_ack_cycle: got ack at cycle %0d, expected single ack at cycle %0d", cyc, t0 + 1);
                end
                acked = 1'b1;
                sq_d.push_back(16'h0200 ^ 16'h5A5A);
                sq_c.push_back(cyc + 2);
            end
            if (scan_rdata_valid) begin
                checks++;
                if (sq_d.size() == 0) begin
                    errors++;
                    $display("FAIL scan_unexpected_valid: got data %h at cycle %0d, expected no valid", scan_rdata, cyc);
                end else begin
                    exp_d = sq_d.pop_front();
                    exp_c = sq_c.pop_front();
                    if (scan_rdata !== exp_d || cyc != exp_c) begin
                        errors++;
                        $display("FAIL scan_data: got %h at cycle %0d, expected %h at cycle %0d", scan_rdata, cyc, exp_d, exp_c);
                    end
                end
            end
            if (i == 0) begin
                t0 = cyc;
                scan_req = 1'b1;
                scan_addr = 16'h0200;
            end else if (acked) begin
                scan_req = 1'b0;
            end
        end
        checks++;
        if (!acked || sq_d.size() != 0) begin
            errors++;
            $display("FAIL scan_complete: got acked=%0b outstanding=%0d, expected acked=1 outstanding=0", acked, sq_d.size());
        end
    endtask

    task automatic test_starve_overflow;
        int t0 = 0;
        int nacks = 0;
        int ack_c[2] = '{0, 0};
        int lat;
        hq_d.delete(); hq_c.delete(); sq_d.delete(); sq_c.delete();
        scan_addr = 16'h0300;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0) t0 = cyc;
            if (scan_ack) begin
                if (nacks < 2) ack_c[nacks] = cyc;
                nacks++;
                sq_d.push_back(scan_addr ^ 16'h5A5A);
                sq_c.push_back(cyc + 2);
                scan_addr = scan_addr + 16'd1;
            end
            if (scan_rdata_valid) begin
                checks++;
                if (sq_d.size() == 0) begin
                    errors++;
                    $display("FAIL starve_scan_unexpected: got data %h at cycle %0d, expected no valid", scan_rdata, cyc);
                end else begin
                    exp_d = sq_d.pop_front();
                    exp_c = sq_c.pop_front();
                    if (scan_rdata !== exp_d || cyc != exp_c) begin
                        errors++;
                        $display("FAIL starve_scan_data: got %h at cycle %0d, expected %h at cycle %0d", scan_rdata, cyc, exp_d, exp_c);
                    end
                end
            end
            if (host_rdata_valid) begin
                checks++;
                if (hq_d.size() == 0) begin
                    errors++;
                    $display("FAIL starve_host_unexpected: got data %h at cycle %0d, expected no valid", host_rdata, cyc);
                end else begin
                    exp_d = hq_d.pop_front();
                    exp_c = hq_c.pop_front();
                    if (host_rdata !== exp_d || cyc != exp_c) begin
                        errors++;
                        $display("FAIL starve_host_data: got %h at cycle %0d, expected %h at cycle %0d", host_rdata, cyc, exp_d, exp_c);
                    end
                end
            end
            if (i == 18 || i == 19 || i == 29) begin
                checks++;
                if (host_overflow !== (i != 18)) begin
                    errors++;
                    $display("FAIL overflow_flag: got %b at step %0d, expected %b", host_overflow, i, i != 18);
                end
            end
            idle_inputs();
            scan_req = (nacks < 2);
            if (i < 20) begin
                host_rd_en = 1'b1;
                host_addr  = 16'h0100 + 16'(i);
                // Slot 8 is taken by the forced scan; later events each wait one cycle in the holding
                // register, event 17 waits two (second forced scan) and event 18 finds it full.
                lat = (i < 8) ? 3 : (i == 17) ? 5 : 4;
                if (i != 18) begin
                    hq_d.push_back((16'h0100 + 16'(i)) ^ 16'h5A5A);
                    hq_c.push_back(cyc + lat);
                end
            end
        end
        checks++;
        if (nacks != 2 || ack_c[0] != t0 + 9 || ack_c[1] != t0 + 19) begin
            errors++;
            $display("FAIL starve_ack_cycles: got %0d acks at +%0d,+%0d, expected 2 acks at +9,+19",
                     nacks, ack_c[0] - t0, ack_c[1] - t0);
        end
        checks++;
        if (hq_d.size() != 0 || sq_d.size() != 0) begin
            errors++;
            $display("FAIL starve_missing: got host=%0d scan=%0d outstanding, expected 0 0", hq_d.size(), sq_d.size());
        end
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (host_overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL overflow_sticky: got %b, expected 1", host_overflow);
                end
            end
            if (i == 1) begin
                checks++;
                if (ram_re !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_read_issue: got ram_re=%b, expected 1", ram_re);
                end
            end
            if (i == 2) begin
                checks++;
                if (outs !== '0) begin
                    errors++;
                    $display("FAIL rst_midflight_outputs: got %h, expected 0", outs);
                end
            end
            if (i > 2 && host_rdata_valid) begin
                checks++;
                errors++;
                $display("FAIL rst_discard: got host_rdata_valid=1 at step %0d, expected 0", i);
            end
            idle_inputs();
            rst = (i == 1);
            if (i == 0) begin
                host_rd_en = 1'b1;
                host_addr  = 16'h0040;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
        test_reset();
        test_write_read();
        test_wr_rd_both();
        test_scan();
        test_starve_overflow();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters.
- Requester 1: the GPMC host path (rd_en/wr_en single-cycle pulses, address, write data).
- Requester 2: the LED scanout engine (level req/ack handshake).
- Host has priority; an anti-starvation counter guarantees the scanout a slot; a one-deep holding register absorbs host accesses that lose a slot.

Parameters:
- ADDR_WIDTH, 16, RAM word address width.
- DATA_WIDTH, 16, RAM word width.
- STARVE_LIMIT, 8, consecutive denied scanout cycles before the scanout is forced ahead of the host (1..255).

Ports:
- gpmc_clk  in  1  single clock; every register in this block runs on it.
- rst  in  1  synchronous reset, active-high.
- host_rd_en  in  1  one-cycle host read pulse.
- host_wr_en  in  1  one-cycle host write pulse.
- host_addr  in  ADDR_WIDTH  host word address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rdata  out  DATA_WIDTH  host read data.
- host_rdata_valid  out  1  one-cycle pulse qualifying host_rdata.
- host_overflow  out  1  sticky: a host access was dropped.
- scan_req  in  1  scanout read request, held until acked.
- scan_addr  in  ADDR_WIDTH  scanout address, stable while scan_req is high.
- scan_ack  out  1  one-cycle pulse: request issued to RAM.
- scan_rdata  out  DATA_WIDTH  scanout read data.
- scan_rdata_valid  out  1  one-cycle pulse qualifying scan_rdata.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_we  out  1  registered write strobe.
- ram_re  out  1  registered read strobe.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re.

Behaviour:
- Reset values: all outputs 0. Holding register empty. Starve counter 0. Read-tag pipeline cleared. host_overflow cleared.
- Host event = host_wr_en or host_rd_en. If both are high in one cycle, the event is a write; the read is ignored.
- Slot grant is decided each cycle. Priority:
  (1) scan, if scan_req and starve counter == STARVE_LIMIT;
  (2) pending host entry in the holding register;
  (3) host event this cycle;
  (4) scan, if scan_req;
  (5) idle.
- The winner drives ram_addr/ram_wdata/ram_we/ram_re on the next cycle. No more than one RAM access per cycle.
- A host event not granted in its arrival cycle is stored in the holding register (addr, data, rd/wr).
- If the holding register is full and also not granted this cycle, a new host event is dropped and host_overflow is set. host_overflow clears only on rst.
- When the holding register is granted and a new host event arrives the same cycle, the new event is loaded into the holding register (no drop).
- Starve counter:
  - increments, saturating at STARVE_LIMIT, each cycle scan_req is high and not granted;
  - clears on a scan grant or when scan_req is low.
- scan_ack pulses in the same cycle ram_re is asserted for the scan access. The scanout must not change scan_addr before it sees scan_ack.
- Read latency: a read tag (host/scan) travels with ram_re. ram_rdata is registered into host_rdata or scan_rdata the cycle after ram_rdata is valid.
  - Undeferred host read: host_rd_en in cycle 0 → ram_re in cycle 1 → host_rdata_valid in cycle 3.
  - Each deferral adds one cycle.
  - Scan read: scan_ack in cycle N → scan_rdata_valid in cycle N+2.
- Writes produce no response pulse.
- Data registers hold their last value when the valid pulse is low.
- A write followed by a read of the same address in the next cycle returns the new data, because RAM accesses are issued strictly in order.
- rst mid-operation: in-flight reads are discarded (no valid pulses after reset). The holding register is emptied; that host access is lost without setting overflow.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, the block adds:
  - input stat_clr;
  - outputs stat_host_grants, stat_scan_grants and stat_defers, each 16 bits.
- All three counters saturate at 16'hFFFF and clear on rst or stat_clr; stat_clr has priority over an increment in the same cycle.
- stat_defers counts host events loaded into the holding register.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Host write 0x0010←0xBEEF, then host read 0x0010 two cycles later, scan_req low → ram_we cycle 1; host_rdata=0xBEEF with valid 3 cycles after the read pulse.
- scan_req held, addr 0x0200, no host traffic → scan_ack the cycle after scan_req rises, then scan_rdata_valid 2 cycles after scan_ack with the RAM contents.
- Continuous host reads every cycle with scan_req high, STARVE_LIMIT=8 → scan_ack after 8 denied cycles; the host read in that slot is deferred one cycle; host_overflow stays 0.
- Host events every cycle while the holding register is full and the scan slot is forced → exactly one event is dropped and host_overflow=1 until rst.
- host_wr_en and host_rd_en asserted together, addr 0x0005, data 0x1234 → one RAM write and no host_rdata_valid.
- rst asserted the cycle after a host read issue → no host_rdata_valid; all outputs 0 the cycle after rst.
